// File: rtl/instr_encoder_loader.sv
// Packs symbolic LEGv8 instruction fields into 32-bit machine words and writes
// them sequentially into instruction memory, one word per accepted beat.
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_op,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rn,
    input  logic [4:0]                 in_rm,
    input  logic [25:0]                in_imm,
    input  logic                       in_last,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       done,
    output logic                       full,
    output logic                       err
);

    localparam int CW      = $clog2(DEPTH + 1);
    localparam int NUM_OPS = 11;

    localparam int OP_ADDI = 0;
    localparam int OP_ADDS = 1;
    localparam int OP_B    = 2;
    localparam int OP_BLT  = 3;
    localparam int OP_CBZ  = 4;
    localparam int OP_LDUR = 5;
    localparam int OP_LSL  = 6;
    localparam int OP_LSR  = 7;
    localparam int OP_MUL  = 8;
    localparam int OP_STUR = 9;
    localparam int OP_SUBS = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state_reg, state_next;
    logic [CW-1:0]       count_reg, count_next;
    logic [ADDR_W-1:0]   wptr_reg, wptr_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic                err_reg, err_next;

    logic [NUM_OPS-1:0]  op_hit;
    logic                fits_u12, fits_u6, fits_s9, fits_s19;
    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                full_w;
    logic                accept;

    // One-hot opcode decode; codes 11..15 leave every bit low and are rejected.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op
            assign op_hit[gi] = (in_op == 4'(gi));
        end
    endgenerate

    // Immediate range checks on the 26-bit two's-complement field.
    assign fits_u12 = (in_imm[25:12] == 14'd0);
    assign fits_u6  = (in_imm[25:6] == 20'd0);
    assign fits_s9  = (in_imm[25:8] == {18{in_imm[8]}});
    assign fits_s19 = (in_imm[25:18] == {8{in_imm[18]}});

    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
        if (op_hit[OP_ADDI]) begin
            enc_word  = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
            enc_legal = fits_u12;
        end
        if (op_hit[OP_ADDS]) begin
            enc_word  = {11'b10101011000, in_rm, 6'd0, in_rn, in_rd};
            enc_legal = 1'b1;
        end
        if (op_hit[OP_SUBS]) begin
            enc_word  = {11'b11101011000, in_rm, 6'd0, in_rn, in_rd};
            enc_legal = 1'b1;
        end
        if (op_hit[OP_MUL]) begin
            enc_word  = {11'b10011011000, in_rm, 6'b011111, in_rn, in_rd};
            enc_legal = 1'b1;
        end
        if (op_hit[OP_LSL]) begin
            enc_word  = {11'b11010011011, 5'd0, in_imm[5:0], in_rn, in_rd};
            enc_legal = fits_u6;
        end
        if (op_hit[OP_LSR]) begin
            enc_word  = {11'b11010011010, 5'd0, in_imm[5:0], in_rn, in_rd};
            enc_legal = fits_u6;
        end
        if (op_hit[OP_LDUR]) begin
            enc_word  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
            enc_legal = fits_s9;
        end
        if (op_hit[OP_STUR]) begin
            enc_word  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
            enc_legal = fits_s9;
        end
        if (op_hit[OP_B]) begin
            enc_word  = {6'b000101, in_imm};
            enc_legal = 1'b1;
        end
        if (op_hit[OP_CBZ]) begin
            enc_word  = {8'b10110100, in_imm[18:0], in_rd};
            enc_legal = fits_s19;
        end
        if (op_hit[OP_BLT]) begin
            // B.cond with the LT condition code hard-wired into the low field.
            enc_word  = {8'b01010100, in_imm[18:0], 5'b01011};
            enc_legal = fits_s19;
        end
    end

    assign full_w   = (count_reg == CW'(DEPTH));
    assign in_ready = (state_reg == S_LOAD) && !full_w;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        wptr_next  = wptr_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_LOAD;
                    count_next = '0;
                    wptr_next  = ADDR_W'(BASE_ADDR);
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (enc_legal) begin
                        we_next    = 1'b1;
                        addr_next  = wptr_reg;
                        wdata_next = enc_word;
                        count_next = count_reg + CW'(1);
                        wptr_next  = wptr_reg + ADDR_W'(4);
                        if (in_last || (count_reg == CW'(DEPTH - 1))) begin
                            state_next = S_DONE;
                        end
                    end else begin
                        // Rejected beats are consumed but leave count and pointer alone.
                        err_next = 1'b1;
                        if (in_last) begin
                            state_next = S_DONE;
                        end
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            count_reg <= '0;
            wptr_reg  <= ADDR_W'(BASE_ADDR);
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            wptr_reg  <= wptr_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            err_reg   <= err_next;
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign count      = count_reg;
    assign done       = (state_reg == S_DONE);
    assign full       = full_w;
    assign err        = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a driver pushes expected imem writes
// and reject pulses from an arithmetic reference model, a monitor pops and compares.
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 10;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;
    localparam int CW        = $clog2(DEPTH + 1);

    localparam int ST_IDLE = 0;
    localparam int ST_LOAD = 1;
    localparam int ST_DONE = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_op = 4'd0;
    logic [4:0]        in_rd = 5'd0;
    logic [4:0]        in_rn = 5'd0;
    logic [4:0]        in_rm = 5'd0;
    logic [25:0]       in_imm = 26'd0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [CW-1:0]     count;
    logic              done;
    logic              full;
    logic              err;

    instr_encoder_loader #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .count     (count),
        .done      (done),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                is_err;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    exp_t sb_q[$];
    int   m_state = ST_IDLE;
    int   m_count = 0;
    int   errors  = 0;
    int   checks  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rfmt(input int opc, input int rm, input int sh,
                                         input int rn, input int rd);
        return (32'(opc) << 21) | (32'(rm) << 16) | (32'(sh) << 10) | (32'(rn) << 5) | 32'(rd);
    endfunction

    // Reference encoder: integer range checks and shifted opcode constants.
    task automatic ref_encode(input int op, input int rd, input int rn, input int rm,
                              input logic [25:0] imm, output bit legal, output logic [31:0] w);
        int s;
        s = int'($signed(imm));
        legal = 1'b1;
        w = 32'd0;
        case (op)
            0: begin
                legal = (s >= 0) && (s <= 4095);
                w = (32'h244 << 22) | (32'(s & 'hFFF) << 10) | (32'(rn) << 5) | 32'(rd);
            end
            1: w = rfmt('h558, rm, 0, rn, rd);
            2: w = (32'h5 << 26) | 32'(s & 'h3FFFFFF);
            3: begin
                legal = (s >= -262144) && (s <= 262143);
                w = (32'h54 << 24) | (32'(s & 'h7FFFF) << 5) | 32'd11;
            end
            4: begin
                legal = (s >= -262144) && (s <= 262143);
                w = (32'hB4 << 24) | (32'(s & 'h7FFFF) << 5) | 32'(rd);
            end
            5, 9: begin
                legal = (s >= -256) && (s <= 255);
                w = (32'(op == 5 ? 'h7C2 : 'h7C0) << 21) | (32'(s & 'h1FF) << 12)
                    | (32'(rn) << 5) | 32'(rd);
            end
            6, 7: begin
                legal = (s >= 0) && (s <= 63);
                w = rfmt(op == 6 ? 'h69B : 'h69A, 0, s & 63, rn, rd);
            end
            8:  w = rfmt('h4D8, rm, 31, rn, rd);
            10: w = rfmt('h758, rm, 0, rn, rd);
            default: legal = 1'b0;
        endcase
    endtask

    function automatic logic [25:0] pick_imm(input int op);
        int lo, hi, v;
        case (op)
            0:       begin lo = 0;         hi = 4095; end
            2:       begin lo = -(1 << 25); hi = (1 << 25) - 1; end
            3, 4:    begin lo = -262144;   hi = 262143; end
            5, 9:    begin lo = -256;      hi = 255; end
            6, 7:    begin lo = 0;         hi = 63; end
            default: return 26'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0:       v = lo;
            1:       v = hi;
            2:       v = lo - 1;
            3:       v = hi + 1;
            default: v = lo + int'($urandom_range(0, 32'(hi - lo)));
        endcase
        return 26'(v);
    endfunction

    // One clock cycle of stimulus; the model advances at the edge the beat would be accepted.
    task automatic step(input bit st, input bit v, input int op, input int rd, input int rn,
                        input int rm, input logic [25:0] imm, input bit last);
        bit          exp_rdy, legal;
        logic [31:0] w;
        exp_t        e;
        start    = st;
        in_valid = v;
        in_op    = 4'(op);
        in_rd    = 5'(rd);
        in_rn    = 5'(rn);
        in_rm    = 5'(rm);
        in_imm   = imm;
        in_last  = last;
        @(negedge clk);
        exp_rdy = (m_state == ST_LOAD) && (m_count < DEPTH);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (v && exp_rdy) begin
            ref_encode(op, rd, rn, rm, imm, legal, w);
            e.is_err = !legal;
            e.addr   = legal ? ADDR_W'(BASE_ADDR + 4 * m_count) : '0;
            e.data   = legal ? w : 32'd0;
            sb_q.push_back(e);
            if (legal) m_count++;
            if (last || (legal && m_count == DEPTH)) m_state = ST_DONE;
        end else if (st && m_state != ST_LOAD) begin
            m_state = ST_LOAD;
            m_count = 0;
        end
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 26'd0, 0);
    endtask

    task automatic do_start();
        step(1, 0, 0, 0, 0, 0, 26'd0, 0);
    endtask

    task automatic beat(input int op, input int rd, input int rn, input int rm,
                        input int imm, input bit last);
        step(0, 1, op, rd, rn, rm, 26'(imm), last);
    endtask

    // Monitor: status every cycle, and one scoreboard item whenever one is due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("count", 32'(count), 32'(m_count));
            chk("full", 32'(full), 32'(m_count == DEPTH));
            chk("done", 32'(done), 32'(m_state == ST_DONE));
            chk("we_err_excl", 32'(imem_we & err), 32'd0);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.is_err) begin
                    chk("err_pulse", 32'(err), 32'd1);
                    chk("err_no_we", 32'(imem_we), 32'd0);
                    $display("txn reject err=%0b we=%0b", err, imem_we);
                end else begin
                    chk("we", 32'(imem_we), 32'd1);
                    chk("addr", 32'(imem_addr), 32'(e.addr));
                    chk("wdata", imem_wdata, e.data);
                    chk("write_no_err", 32'(err), 32'd0);
                    $display("txn write addr=0x%03h wdata=0x%08h exp=0x%08h", imem_addr, imem_wdata, e.data);
                end
            end else begin
                chk("idle_we", 32'(imem_we), 32'd0);
                chk("idle_err", 32'(err), 32'd0);
            end
        end
    end

    initial begin
        #2;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Mixed session: ADDI, ADDS, CBZ, B.LT; fills DEPTH and ends at once.
        do_start();
        beat(0, 1, 2, 0, 5, 0);
        beat(1, 3, 1, 2, 0, 0);
        beat(4, 0, 0, 0, -1, 0);
        beat(3, 0, 0, 0, 3, 1);
        idle(2);

        // in_last ends a short session before full.
        do_start();
        beat(1, 3, 1, 2, 0, 0);
        beat(4, 0, 0, 0, -1, 0);
        beat(3, 0, 0, 0, 3, 1);
        idle(2);

        // STUR, then rejected LDUR out of range and illegal opcode.
        do_start();
        beat(9, 5, 6, 0, -8, 0);
        beat(5, 1, 2, 0, 256, 0);
        beat(12, 1, 2, 3, 0, 0);
        idle(1);
        beat(5, 7, 8, 0, -256, 0);
        beat(6, 1, 2, 0, 64, 1);
        idle(2);

        // Five beats held valid against DEPTH=4; restart writes at base again.
        do_start();
        for (int i = 0; i < 5; i++) beat(8, i, i + 1, i + 2, 0, 0);
        idle(1);
        do_start();
        beat(10, 9, 10, 11, 0, 0);
        step(1, 0, 0, 0, 0, 0, 26'd0, 0);
        beat(7, 4, 5, 0, 63, 0);

        // Asynchronous reset while a write strobe is high.
        #1;
        chk("pre_rst_we", 32'(imem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_we", 32'(imem_we), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd0);
        sb_q.delete();
        m_state = ST_IDLE;
        m_count = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        beat(0, 1, 1, 1, 1, 0);
        beat(2, 0, 0, 0, 7, 1);

        // Randomized sessions with gaps, stray starts and boundary immediates.
        for (int s = 0; s < 40; s++) begin
            step(1, $urandom_range(0, 1), 0, 1, 1, 1, 26'd1, 0);
            for (int b = 0; b < int'($urandom_range(1, 7)); b++) begin
                int op;
                if ($urandom_range(0, 3) == 0) idle(1);
                op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 15))
                                                 : int'($urandom_range(0, 10));
                step($urandom_range(0, 7) == 0, 1, op, $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), pick_imm(op), $urandom_range(0, 4) == 0);
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
